ifetch_q: RTL and testbench
===========================

Name: ifetch_q

Overview:
- Instruction fetch stage with a small prefetch queue.
- Generates sequential PCs and issues requests on the instruction bus.
- Buffers the returned words and presents one instruction per cycle (IDATA plus its PC) to the decode stage, whose immediate extender consumes IDATA directly.
- Handles pipeline stalls (HLT) and control-flow redirects (JREQ), flushing stale prefetched words.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- DEPTH, 2, prefetch queue entries; power of two, ≥2.
- NOP, 32'h00000013, word driven on IDATA when no valid instruction is present (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RES  in  1  synchronous active-high reset.
- HLT  in  1  downstream stall; head entry is not consumed while high.
- JREQ  in  1  redirect request (branch/jump taken), one-cycle pulse.
- JVAL  in  32  redirect target; bits [1:0] ignored and forced to 0.
- IREQ  out  1  instruction bus request.
- IADDR  out  32  instruction bus address, word aligned.
- IACK  in  1  bus accepts the request and returns IDIN in the same cycle.
- IDIN  in  32  instruction word from the bus.
- IVALID  out  1  IDATA/IPC hold a valid instruction.
- IDATA  out  32  instruction to decode/ext; NOP when IVALID=0.
- IPC  out  32  PC of IDATA; holds its last value when IVALID=0.

Behaviour:
- Reset (RES=1 at an edge):
  - PC←RESET_PC; queue empty; FSM←BOOT.
  - IREQ=0, IVALID=0, IDATA=NOP, IPC=RESET_PC.
  - Reset overrides JREQ, IACK and everything else in the same cycle.
- FSM:
  - BOOT: one cycle, no request; always goes to RUN.
  - RUN: normal operation.
- Issue (RUN only):
  - IREQ=1 when free space is available, i.e. count<DEPTH, or count==DEPTH and a pop occurs this cycle.
  - IADDR=PC.
- Fill: on IREQ&IACK&!JREQ, push {PC,IDIN} and set PC←PC+4. PC wraps from 32'hFFFFFFFC to 0.
- Pop: when IVALID&!HLT, the head is consumed at the edge. Push and pop in the same cycle are both performed; count is unchanged.
- IVALID=(count!=0). IDATA and IPC come combinationally from the queue head.
- Latency: IACK in cycle N → IVALID in cycle N+1 (queue registered).
- Redirect (JREQ=1):
  - At the edge: queue cleared, PC←{JVAL[31:2],2'b00}.
  - Any word returned in that cycle (IACK) is discarded.
  - The pop in that cycle is suppressed, i.e. treated as a stall.
  - IREQ may be asserted that cycle, but its response is discarded and PC does not advance on it.
  - The first request to JVAL is issued the next cycle.
- HLT=1 with a full queue: IREQ=0 and PC holds. Queue contents and outputs are stable.
- HLT together with JREQ: JREQ wins and the queue is flushed.
- IACK=0: the request stays asserted with IADDR unchanged until accepted.
- IACK while IREQ=0 is ignored.

Optional Feature:
- IFETCH_BYPASS_EN
  - Defined: when the queue is empty (and no JREQ), IDIN is forwarded combinationally to IDATA/IPC with IVALID=1 in the same cycle as IACK.
    - If that cycle also pops (HLT=0), the word is not pushed.
    - Fetch-to-decode latency becomes 0.
  - Undefined: latency is 1 cycle as above.

Decomposition:
- Shared package darkriscv_pkg holds:
  - NOP constant.
  - Default RESET_PC.
  - FSM state typedef {BOOT, RUN}.
  - Fetch-entry struct {pc[31:0], insn[31:0]}.
- Sub-module ifetch_fifo: synchronous-reset FIFO of fetch entries.
  - Ports: push, pop, clear, head, count, full, empty.
  - Simultaneous push+pop supported.
  - clear takes priority over push and pop.

Test Plan:
- Reset then free-run, IACK=1 constant, memory returns word=addr^32'hA5A50000, HLT=0 → IREQ=0 in BOOT. IVALID rises 2 cycles after reset release. IPC sequence is 0,4,8,… with matching IDATA, one per cycle.
- HLT=1 held for 5 cycles from cycle 10 → queue fills to DEPTH, then IREQ=0, IADDR stable, IDATA/IPC constant. After release no instruction is lost or duplicated.
- JREQ pulse with JVAL=32'h00000103 while the queue holds 2 entries and IACK=1 → next cycle IVALID=0 and IADDR=32'h00000100. Following IPCs are 0x100, 0x104; no pre-redirect PC appears.
- IACK random at 50% with HLT random at 30% → the IPC stream is strictly +4 contiguous and every IDATA matches the model memory.
- RESET_PC=32'hFFFFFFF8, free-run → IPCs are FFFFFFF8, FFFFFFFC, 00000000.
- RES asserted mid-stream with the queue full and JREQ=1 → next cycle IVALID=0, IDATA=NOP, IPC=RESET_PC, IREQ=0. With IFETCH_BYPASS_EN: empty queue plus IACK gives IVALID the same cycle.

Source files
------------

// File: rtl/darkriscv_pkg.sv
// Shared fetch-stage types and constants: default reset PC, the NOP filler word,
// the fetch FSM state and the {pc, insn} entry held by the prefetch queue.
package darkriscv_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h00000013;
  localparam logic [31:0] DEF_RESET_PC = 32'h00000000;

  typedef enum logic {
    BOOT,
    RUN
  } fsm_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue of fetch entries with synchronous reset.
// Push and pop in one cycle are both honoured; clear beats push and pop.
module ifetch_fifo
  import darkriscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  fetch_entry_t             i_din,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_q.sv
// Instruction fetch stage: sequential PC generation, bus requests and a prefetch queue
// feeding decode. Define IFETCH_BYPASS_EN to forward IDIN straight to decode when empty.
module ifetch_q
  import darkriscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        JREQ,
  input  logic [31:0] JVAL,
  output logic        IREQ,
  output logic [31:0] IADDR,
  input  logic        IACK,
  input  logic [31:0] IDIN,
  output logic        IVALID,
  output logic [31:0] IDATA,
  output logic [31:0] IPC
);

  fsm_state_t             r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_ipc_last;

  fetch_entry_t           w_head;
  fetch_entry_t           w_din;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_qpop;
  logic                   w_acc;
  logic                   w_byp;
  logic                   w_push;

  // Queue-only pop term; keeps IREQ independent of the bypass path (no comb loop).
  assign w_qpop = !w_empty && !HLT && !JREQ;
  assign IREQ   = (r_state == RUN) && (!w_full || w_qpop);
  assign IADDR  = r_pc;
  assign w_acc  = IREQ && IACK && !JREQ;

`ifdef IFETCH_BYPASS_EN
  assign w_byp = w_empty && w_acc;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word consumed by decode this cycle never enters the queue.
  assign w_push = w_acc && !(w_byp && !HLT);
  assign w_din  = '{pc: r_pc, insn: IDIN};

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RES),
    .i_push  (w_push),
    .i_pop   (w_qpop),
    .i_clear (JREQ),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    IVALID = (w_count != '0);
    IDATA  = w_head.insn;
    IPC    = w_head.pc;
    if (w_count == '0) begin
      if (w_byp) begin
        IVALID = 1'b1;
        IDATA  = IDIN;
        IPC    = r_pc;
      end else begin
        IDATA  = NOP;
        IPC    = r_ipc_last;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_ipc_last <= RESET_PC;
    end else begin
      case (r_state)
        BOOT:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (JREQ) begin
        r_pc <= word_align(JVAL);
      end else if (w_acc) begin
        r_pc <= r_pc + 32'd4;
      end
      if (IVALID) begin
        r_ipc_last <= IPC;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_q.sv
// Scoreboard bench for ifetch_q: stimulus queues expected PCs, a negedge monitor
// checks every consumed instruction against them and the model memory.
module tb_ifetch_q;

  logic        CLK = 1'b0;
  logic        RES, HLT, JREQ, IACK;
  logic [31:0] JVAL;
  wire         IREQ, IVALID;
  wire  [31:0] IADDR, IDATA, IPC, IDIN;

  logic        HLT2  = 1'b0;
  logic        JREQ2 = 1'b0;
  logic        IACK2 = 1'b1;
  logic [31:0] JVAL2 = 32'h0;
  wire         IREQ2, IVALID2;
  wire  [31:0] IADDR2, IDATA2, IPC2, IDIN2;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] mon_e, mon2_e;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  assign IDIN  = mem(IADDR);
  assign IDIN2 = mem(IADDR2);

  ifetch_q u_dut (
    .CLK(CLK), .RES(RES), .HLT(HLT), .JREQ(JREQ), .JVAL(JVAL),
    .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IDIN(IDIN),
    .IVALID(IVALID), .IDATA(IDATA), .IPC(IPC)
  );

  ifetch_q #(.RESET_PC(32'hFFFFFFF8)) u_dut2 (
    .CLK(CLK), .RES(RES), .HLT(HLT2), .JREQ(JREQ2), .JVAL(JVAL2),
    .IREQ(IREQ2), .IADDR(IADDR2), .IACK(IACK2), .IDIN(IDIN2),
    .IVALID(IVALID2), .IDATA(IDATA2), .IPC(IPC2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Main monitor: every instruction handed to decode must be the next expected PC.
  always @(negedge CLK) begin
    if (!RES && !JREQ && IVALID && !HLT) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ipc_unexpected: got %h expected none at %0t", IPC, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ipc", IPC, mon_e);
        chk("idata", IDATA, mem(mon_e));
        n_consumed++;
      end
    end
  end

  // Wrap monitor for the second instance.
  always @(negedge CLK) begin
    if (!RES && IVALID2 && exp2_q.size() != 0) begin
      mon2_e = exp2_q.pop_front();
      chk("wrap_ipc", IPC2, mon2_e);
      chk("wrap_idata", IDATA2, mem(mon2_e));
    end
  end

  initial begin
    int c0;
    RES  = 1'b1;
    HLT  = 1'b0;
    JREQ = 1'b0;
    JVAL = 32'h0;
    IACK = 1'b1;
    for (int i = 0; i < 4; i++) exp2_q.push_back(32'hFFFFFFF8 + 32'(4 * i));
    for (int i = 0; i < 2000; i++) exp_q.push_back(32'(4 * i));

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_b("rst_ireq", IREQ, 1'b0);
    chk_b("rst_ivalid", IVALID, 1'b0);
    chk("rst_idata", IDATA, 32'h00000013);
    chk("rst_ipc", IPC, 32'h0);

    // Release: BOOT (no request), RUN issues, data visible one cycle later
    @(posedge CLK);
    #1 RES = 1'b0;
    @(negedge CLK);
    chk_b("boot_ireq", IREQ, 1'b0);
    chk_b("boot_ivalid", IVALID, 1'b0);
    @(negedge CLK);
    chk_b("run_ireq", IREQ, 1'b1);
    chk("run_iaddr", IADDR, 32'h0);
`ifdef IFETCH_BYPASS_EN
    chk_b("first_ivalid", IVALID, 1'b1);
`else
    chk_b("first_ivalid", IVALID, 1'b0);
`endif
    @(negedge CLK);
    chk_b("second_ivalid", IVALID, 1'b1);

    // Free run, then hold HLT for 5 cycles
    step(8);
    HLT = 1'b1;
    step(3);
    @(negedge CLK);
    chk_b("hlt_ireq", IREQ, 1'b0);
    chk_b("hlt_ivalid", IVALID, 1'b1);
    chk("hlt_ipc", IPC, exp_q[0]);
    chk("hlt_idata", IDATA, mem(exp_q[0]));
    chk("hlt_iaddr", IADDR, exp_q[0] + 32'd8);
    step(2);
    @(negedge CLK);
    chk_b("hlt_ireq_late", IREQ, 1'b0);
    chk("hlt_ipc_late", IPC, exp_q[0]);
    chk("hlt_iaddr_late", IADDR, exp_q[0] + 32'd8);
    HLT = 1'b0;
    step(5);

    // Fill the queue, then redirect to 0x103 (aligned to 0x100)
    HLT = 1'b1;
    step(2);
    HLT  = 1'b0;
    JREQ = 1'b1;
    JVAL = 32'h00000103;
    exp_q.delete();
    for (int i = 0; i < 2000; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    step(1);
    JREQ = 1'b0;
    IACK = 1'b0;
    @(negedge CLK);
    chk_b("jmp_ivalid", IVALID, 1'b0);
    chk_b("jmp_ireq", IREQ, 1'b1);
    chk("jmp_iaddr", IADDR, 32'h100);
    step(1);
    @(negedge CLK);
    chk_b("nack_ireq", IREQ, 1'b1);
    chk("nack_iaddr", IADDR, 32'h100);
    chk_b("nack_ivalid", IVALID, 1'b0);
    IACK = 1'b1;
    step(6);

    // Random bus acks and stalls
    c0 = n_consumed;
    for (int i = 0; i < 300; i++) begin
      IACK = ($urandom % 2) == 0;
      HLT  = ($urandom % 10) < 3;
      step(1);
    end
    IACK = 1'b1;
    HLT  = 1'b0;
    step(4);
    chk_b("random_progress", (n_consumed - c0) >= 40, 1'b1);

    // Reset with a full queue and a concurrent redirect
    HLT = 1'b1;
    step(3);
    RES  = 1'b1;
    JREQ = 1'b1;
    JVAL = 32'h00000200;
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(32'(4 * i));
    step(1);
    RES  = 1'b0;
    JREQ = 1'b0;
    HLT  = 1'b0;
    @(negedge CLK);
    chk_b("mrst_ivalid", IVALID, 1'b0);
    chk("mrst_idata", IDATA, 32'h00000013);
    chk("mrst_ipc", IPC, 32'h0);
    chk_b("mrst_ireq", IREQ, 1'b0);
    c0 = n_consumed;
    step(10);
    chk_b("mrst_progress", (n_consumed - c0) >= 7, 1'b1);

    chk("wrap_all_seen", 32'(exp2_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
